// File: rtl/id_ctrl_stage_pkg.sv
// Shared opcode, ALU-command and branch encodings plus the ID/EX control bundle.
// Imported by the decoder, the stage top and its interface.
package ctrl_pkg;

    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned EXE_CMD_W = 4;
    localparam int unsigned REG_W     = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_SLA  = 6'd9;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 6'd10;
    localparam logic [OPCODE_W-1:0] OP_SRA  = 6'd11;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 6'd12;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd32;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 6'd33;
    localparam logic [OPCODE_W-1:0] OP_LD   = 6'd36;
    localparam logic [OPCODE_W-1:0] OP_ST   = 6'd37;
    localparam logic [OPCODE_W-1:0] OP_BEZ  = 6'd40;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'd41;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'd42;

    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'd0;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'd2;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'd4;
    localparam logic [EXE_CMD_W-1:0] EXE_OR  = 4'd5;
    localparam logic [EXE_CMD_W-1:0] EXE_NOR = 4'd6;
    localparam logic [EXE_CMD_W-1:0] EXE_XOR = 4'd7;
    localparam logic [EXE_CMD_W-1:0] EXE_SHL = 4'd8;
    localparam logic [EXE_CMD_W-1:0] EXE_SRA = 4'd9;
    localparam logic [EXE_CMD_W-1:0] EXE_SRL = 4'd10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef struct packed {
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic [1:0]           branch_type;
        logic                 mem_read;
        logic                 mem_write;
        logic                 wb_en;
        logic                 is_imm;
        logic                 illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ctrl_stage_if.sv
// IF/ID -> ID/EX bus: instruction handshake in, decoded control bundle out.
// master = upstream/downstream environment, slave = the decode stage.
interface id_ctrl_stage_if;
    import ctrl_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPCODE_W-1:0]  in_opcode;
    logic [REG_W-1:0]     in_dest;
    logic [REG_W-1:0]     in_src1;
    logic [REG_W-1:0]     in_src2;

    logic                 out_valid;
    logic [EXE_CMD_W-1:0] out_exe_cmd;
    logic [1:0]           out_branch_type;
    logic                 out_mem_read;
    logic                 out_mem_write;
    logic                 out_wb_en;
    logic                 out_is_imm;
    logic [REG_W-1:0]     out_dest;
    logic                 out_illegal;

    modport master (
        output in_valid, in_opcode, in_dest, in_src1, in_src2,
        input  in_ready,
        input  out_valid, out_exe_cmd, out_branch_type, out_mem_read, out_mem_write,
        input  out_wb_en, out_is_imm, out_dest, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_dest, in_src1, in_src2,
        output in_ready,
        output out_valid, out_exe_cmd, out_branch_type, out_mem_read, out_mem_write,
        output out_wb_en, out_is_imm, out_dest, out_illegal
    );

endinterface

// File: rtl/id_ctrl_stage_decode.sv
// Combinational opcode decoder: control bundle plus which source registers are read.
// Illegal opcodes read no sources, so they can never trigger a load-use bubble.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_bundle_t        ctrl_o,
    output logic                uses_src1_o,
    output logic                uses_src2_o
);

    always_comb begin
        ctrl_o      = CTRL_BUBBLE;
        uses_src1_o = 1'b1;
        uses_src2_o = 1'b0;
        case (opcode_i)
            OP_ADD:  begin ctrl_o.exe_cmd = EXE_ADD; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_SUB:  begin ctrl_o.exe_cmd = EXE_SUB; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_AND:  begin ctrl_o.exe_cmd = EXE_AND; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_OR:   begin ctrl_o.exe_cmd = EXE_OR;  ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_NOR:  begin ctrl_o.exe_cmd = EXE_NOR; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_XOR:  begin ctrl_o.exe_cmd = EXE_XOR; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_SLA:  begin ctrl_o.exe_cmd = EXE_SHL; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_SLL:  begin ctrl_o.exe_cmd = EXE_SHL; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_SRA:  begin ctrl_o.exe_cmd = EXE_SRA; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_SRL:  begin ctrl_o.exe_cmd = EXE_SRL; ctrl_o.wb_en = 1'b1; uses_src2_o = 1'b1; end
            OP_ADDI: begin ctrl_o.exe_cmd = EXE_ADD; ctrl_o.is_imm = 1'b1; ctrl_o.wb_en = 1'b1; end
            OP_SUBI: begin ctrl_o.exe_cmd = EXE_SUB; ctrl_o.is_imm = 1'b1; ctrl_o.wb_en = 1'b1; end
            OP_LD: begin
                ctrl_o.exe_cmd  = EXE_ADD;
                ctrl_o.is_imm   = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.wb_en    = 1'b1;
            end
            // Store data comes from src2 while the address is base+imm.
            OP_ST: begin
                ctrl_o.exe_cmd   = EXE_ADD;
                ctrl_o.is_imm    = 1'b1;
                ctrl_o.mem_write = 1'b1;
                uses_src2_o      = 1'b1;
            end
            OP_BEZ:  ctrl_o.branch_type = BR_BEZ;
            OP_BNE:  begin ctrl_o.branch_type = BR_BNE; uses_src2_o = 1'b1; end
            OP_JMP:  begin ctrl_o.branch_type = BR_JMP; uses_src1_o = 1'b0; end
            default: begin ctrl_o.illegal = 1'b1; uses_src1_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control stage: decode, load-use bubble insertion, stall/flush priority and a
// saturating count of inserted load-use bubbles.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ctrl_stage_if.slave   bus,
    input  logic             ex_stall,
    input  logic             flush,
    output logic [CNT_W-1:0] hazard_cnt
);

    ctrl_bundle_t     dec_ctrl;
    logic             uses_src1;
    logic             uses_src2;
    logic             hazard;
    logic             valid_d, valid_q;
    ctrl_bundle_t     ctrl_d, ctrl_q;
    logic [REG_W-1:0] dest_d, dest_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    ctrl_decode u_decode (
        .opcode_i    (bus.in_opcode),
        .ctrl_o      (dec_ctrl),
        .uses_src1_o (uses_src1),
        .uses_src2_o (uses_src2)
    );

    // r0 is hard-wired zero, so a load into it never creates a dependency.
    assign hazard = valid_q & ctrl_q.mem_read & (dest_q != '0) & bus.in_valid &
                    ((uses_src1 & (bus.in_src1 == dest_q)) |
                     (uses_src2 & (bus.in_src2 == dest_q)));

    assign bus.in_ready = flush | (~ex_stall & ~hazard);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            dest_d  = '0;
        end else if (!ex_stall) begin
            if (hazard) begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
                dest_d  = '0;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (bus.in_valid) begin
                valid_d = 1'b1;
                ctrl_d  = dec_ctrl;
                dest_d  = bus.in_dest;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
                dest_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_exe_cmd     = ctrl_q.exe_cmd;
    assign bus.out_branch_type = ctrl_q.branch_type;
    assign bus.out_mem_read    = ctrl_q.mem_read;
    assign bus.out_mem_write   = ctrl_q.mem_write;
    assign bus.out_wb_en       = ctrl_q.wb_en;
    assign bus.out_is_imm      = ctrl_q.is_imm;
    assign bus.out_illegal     = ctrl_q.illegal;
    assign bus.out_dest        = dest_q;
    assign hazard_cnt          = cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus randomized traffic, all checked against
// an instruction-level model of the ID/EX register and bubble counter.
module tb_id_ctrl_stage;
    import ctrl_pkg::*;

    typedef struct {
        bit v;
        int op, d, s1, s2;
        bit st, fl, rdy;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ctrl_stage_if bus ();
    id_ctrl_stage_if bus2 ();
    logic        ex_stall, flush;
    logic        ex_stall2, flush2;
    logic [15:0] hcnt;
    logic [1:0]  hcnt2;

    id_ctrl_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ex_stall(ex_stall), .flush(flush),
        .hazard_cnt(hcnt)
    );
    id_ctrl_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .ex_stall(ex_stall2), .flush(flush2),
        .hazard_cnt(hcnt2)
    );

    logic [16:0] obs;
    assign obs = {bus.out_valid, bus.out_exe_cmd, bus.out_branch_type, bus.out_mem_read,
                  bus.out_mem_write, bus.out_wb_en, bus.out_is_imm, bus.out_illegal,
                  bus.out_dest};

    int n_checks = 0;
    int n_pass = 0;

    // Model: which instruction sits in ID/EX, and how many bubbles were inserted.
    bit         m_valid;
    int         m_op;
    logic [4:0] m_dest;
    int         m_cnt;

    function automatic bit legal(int op);
        return op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
    endfunction

    function automatic bit use1(int op);
        return legal(op) && op != 42;
    endfunction

    function automatic bit use2(int op);
        return legal(op) && (op <= 12 || op == 37 || op == 41);
    endfunction

    // {exe_cmd, branch_type, mem_read, mem_write, wb_en, is_imm, illegal}
    function automatic logic [10:0] ref_ctrl(int op);
        int cmd = 0;
        int br = 0;
        bit wb, imm;
        case (op)
            3, 33:  cmd = 2;
            5:      cmd = 4;
            6:      cmd = 5;
            7:      cmd = 6;
            8:      cmd = 7;
            9, 10:  cmd = 8;
            11:     cmd = 9;
            12:     cmd = 10;
            40:     br = 1;
            41:     br = 2;
            42:     br = 3;
            default: cmd = 0;
        endcase
        wb  = legal(op) && (op <= 12 || op == 32 || op == 33 || op == 36);
        imm = op inside {32, 33, 36, 37};
        return {cmd[3:0], br[1:0], op == 36, op == 37, wb, imm, !legal(op)};
    endfunction

    function automatic logic [16:0] exp_out();
        return m_valid ? {1'b1, ref_ctrl(m_op), m_dest} : 17'd0;
    endfunction

    function automatic bit m_hazard();
        int op = int'(bus.in_opcode);
        return m_valid && m_op == 36 && m_dest != 0 && bus.in_valid &&
               ((use1(op) && bus.in_src1 == m_dest) || (use2(op) && bus.in_src2 == m_dest));
    endfunction

    function automatic bit exp_ready();
        return flush || (!ex_stall && !m_hazard());
    endfunction

    task automatic model_edge();
        if (flush) begin
            m_valid = 0;
        end else if (!ex_stall) begin
            if (m_hazard()) begin
                m_valid = 0;
                if (m_cnt < 65535) m_cnt++;
            end else if (bus.in_valid) begin
                m_valid = 1;
                m_op    = int'(bus.in_opcode);
                m_dest  = bus.in_dest;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int op, input int d, input int s1, input int s2,
                         input bit st, input bit fl);
        bus.in_valid  = v;
        bus.in_opcode = op[5:0];
        bus.in_dest   = d[4:0];
        bus.in_src1   = s1[4:0];
        bus.in_src2   = s2[4:0];
        ex_stall      = st;
        flush         = fl;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        n_checks++;
        if (obs !== 17'd0) $display("FAIL reset_outputs: got %h want 0", obs); else n_pass++;
        n_checks++;
        if (hcnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", hcnt); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_valid = 0;
        m_cnt = 0;
    endtask

    task automatic test_decode_sweep();
        for (int op = 0; op < 64; op++) begin
            drive(1, op, (op % 31) + 1, 0, 0, 0, 0);
            n_checks++;
            if (bus.in_ready !== 1'b1) $display("FAIL sweep_ready op=%0d: got %b want 1", op,
                                                bus.in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL sweep_decode op=%0d: got %h want %h", op, obs,
                                            exp_out());
            else n_pass++;
            if (op == 2 || op == 13 || op == 63) begin
                n_checks++;
                if (bus.out_illegal !== 1'b1) $display("FAIL sweep_illegal op=%0d: got %b want 1",
                                                       op, bus.out_illegal);
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_use();
        step_t s[6];
        int c0 = m_cnt;
        s = '{'{1, 36, 4, 0, 0, 0, 0, 1}, '{1, 1, 9, 4, 0, 0, 0, 0}, '{1, 1, 9, 4, 0, 0, 0, 1},
              '{1, 36, 0, 0, 0, 0, 0, 1}, '{1, 1, 9, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 1}};
        foreach (s[i]) begin
            drive(s[i].v, s[i].op, s[i].d, s[i].s1, s[i].s2, s[i].st, s[i].fl);
            n_checks++;
            if (bus.in_ready !== s[i].rdy || s[i].rdy != exp_ready())
                $display("FAIL load_use_ready step %0d: got %b want %b", i, bus.in_ready, s[i].rdy);
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL load_use_out step %0d: got %h want %h", i, obs,
                                            exp_out());
            else n_pass++;
        end
        n_checks++;
        if (hcnt !== 16'(c0 + 1)) $display("FAIL load_use_cnt: got %0d want %0d", hcnt, c0 + 1);
        else n_pass++;
    endtask

    task automatic test_store_dep();
        step_t s[5];
        s = '{'{1, 36, 7, 0, 0, 0, 0, 1}, '{1, 37, 0, 1, 7, 0, 0, 0}, '{1, 37, 0, 1, 7, 0, 0, 1},
              '{1, 36, 7, 0, 0, 0, 0, 1}, '{1, 32, 3, 1, 7, 0, 0, 1}};
        foreach (s[i]) begin
            drive(s[i].v, s[i].op, s[i].d, s[i].s1, s[i].s2, s[i].st, s[i].fl);
            n_checks++;
            if (bus.in_ready !== s[i].rdy || s[i].rdy != exp_ready())
                $display("FAIL store_dep_ready step %0d: got %b want %b", i, bus.in_ready,
                         s[i].rdy);
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL store_dep_out step %0d: got %h want %h", i, obs,
                                            exp_out());
            else n_pass++;
            n_checks++;
            if (hcnt !== m_cnt[15:0]) $display("FAIL store_dep_cnt step %0d: got %0d want %0d", i,
                                               hcnt, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        step_t s[6];
        s = '{'{1, 36, 2, 0, 0, 0, 0, 1}, '{1, 1, 5, 2, 0, 1, 0, 0}, '{1, 1, 5, 2, 0, 1, 0, 0},
              '{1, 1, 5, 2, 0, 1, 0, 0}, '{1, 1, 5, 2, 0, 0, 0, 0}, '{1, 1, 5, 2, 0, 0, 0, 1}};
        foreach (s[i]) begin
            drive(s[i].v, s[i].op, s[i].d, s[i].s1, s[i].s2, s[i].st, s[i].fl);
            n_checks++;
            if (bus.in_ready !== s[i].rdy || s[i].rdy != exp_ready())
                $display("FAIL stall_ready step %0d: got %b want %b", i, bus.in_ready, s[i].rdy);
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL stall_out step %0d: got %h want %h", i, obs,
                                            exp_out());
            else n_pass++;
            n_checks++;
            if (hcnt !== m_cnt[15:0]) $display("FAIL stall_cnt step %0d: got %0d want %0d", i,
                                               hcnt, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        step_t s[5];
        s = '{'{1, 36, 3, 0, 0, 0, 0, 1}, '{1, 1, 5, 3, 0, 1, 1, 1}, '{1, 1, 5, 3, 0, 0, 0, 1},
              '{1, 42, 0, 0, 0, 0, 1, 1}, '{1, 40, 0, 6, 0, 0, 0, 1}};
        foreach (s[i]) begin
            drive(s[i].v, s[i].op, s[i].d, s[i].s1, s[i].s2, s[i].st, s[i].fl);
            n_checks++;
            if (bus.in_ready !== s[i].rdy || s[i].rdy != exp_ready())
                $display("FAIL flush_ready step %0d: got %b want %b", i, bus.in_ready, s[i].rdy);
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL flush_out step %0d: got %h want %h", i, obs,
                                            exp_out());
            else n_pass++;
            n_checks++;
            if (hcnt !== m_cnt[15:0]) $display("FAIL flush_cnt step %0d: got %0d want %0d", i,
                                               hcnt, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int pool[21] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 36, 36, 37, 40, 41, 42,
                         13, 63};
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 4) != 0, pool[$urandom_range(0, 20)], $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0);
            n_checks++;
            if (bus.in_ready !== exp_ready()) $display("FAIL random_ready cycle %0d: got %b want %b",
                                                       i, bus.in_ready, exp_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL random_out cycle %0d: got %h want %h", i, obs,
                                            exp_out());
            else n_pass++;
            n_checks++;
            if (hcnt !== m_cnt[15:0]) $display("FAIL random_cnt cycle %0d: got %0d want %0d", i,
                                               hcnt, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 1, 6, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL mid_reset_pre: got %b want 1", bus.out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 17'd0) $display("FAIL mid_reset_out: got %h want 0", obs); else n_pass++;
        n_checks++;
        if (hcnt !== 16'd0) $display("FAIL mid_reset_cnt: got %0d want 0", hcnt); else n_pass++;
        m_valid = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        int exp_c;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1; bus2.in_opcode = 6'd36; bus2.in_dest = 5'd3;
            bus2.in_src1 = 5'd0; bus2.in_src2 = 5'd0;
            @(posedge clk); #1;
            bus2.in_opcode = 6'd1; bus2.in_dest = 5'd8; bus2.in_src1 = 5'd3;
            #1;
            n_checks++;
            if (bus2.in_ready !== 1'b0) $display("FAIL sat_ready iter %0d: got %b want 0", i,
                                                 bus2.in_ready);
            else n_pass++;
            @(posedge clk); #1;
            exp_c = (i + 1 > 3) ? 3 : i + 1;
            n_checks++;
            if (hcnt2 !== exp_c[1:0]) $display("FAIL sat_cnt iter %0d: got %0d want %0d", i, hcnt2,
                                               exp_c);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus2.in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus2.in_valid = 0; bus2.in_opcode = '0; bus2.in_dest = '0;
        bus2.in_src1 = '0; bus2.in_src2 = '0;
        ex_stall2 = 0; flush2 = 0;
        m_valid = 0; m_op = 0; m_dest = '0; m_cnt = 0;
        test_reset();
        test_decode_sweep();
        test_load_use();
        test_store_dep();
        test_stall();
        test_flush();
        test_random();
        test_saturate();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
